// File: rtl/text_pkg.sv
// Shared definitions for the text console and textmode-side address logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: sequencer state encoding, control character codes, blank glyph,
// default screen geometry shared with the top level.
package text_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_ADVANCE    = 3'd2,
    ST_CLEAR_LINE = 3'd3,
    ST_CLEAR_ALL  = 3'd4
  } state_t;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam int TRAM_HRES_DEF = 84;
  localparam int TRAM_VRES_DEF = 24;

endpackage

// File: rtl/tram_addr_wrap.sv
// Circular tram address: offs + idx, folded back once into 0..SIZE-1.
// Latency: combinational.
// Backpressure: none.
//
// Ports: offs - circular base (first displayed word), idx - linear index
// within the screen, addr - physical tram address.
// Both operands are below SIZE, so a single conditional subtract is enough;
// the sum is formed one bit wider so it never wraps modulo 2^ADDRW.
module tram_addr_wrap #(
  parameter int ADDRW = 11,
  parameter int SIZE  = 2016
) (
  input  logic [ADDRW-1:0] offs,
  input  logic [ADDRW-1:0] idx,
  output logic [ADDRW-1:0] addr
);

  localparam logic [ADDRW:0] SIZE_W = (ADDRW+1)'(SIZE);

  logic [ADDRW:0] sum;
  logic [ADDRW:0] folded;

  always_comb begin
    sum    = {1'b0, offs} + {1'b0, idx};
    folded = (sum >= SIZE_W) ? (sum - SIZE_W) : sum;
    addr   = folded[ADDRW-1:0];
  end

endmodule

// File: rtl/text_console.sv
// Character stream to tram write sequencer; owns cursor and scroll offset.
// Latency: char accepted at cycle N is written at N+1; ready again at N+2.
// Backpressure: in_ready low outside IDLE, incl. HRES-cycle line clear and SIZE-cycle clear.
//
// Ports: clk_sys/rst_sys (sync, active-high); in_valid/in_ready/in_char/in_attr
// character input; busy; tram_we/tram_addr/tram_din tram write port;
// scroll_offs to textmode; cur_col/cur_row cursor position.
// Build option: define TEXT_CONSOLE_TAB_EN to treat 0x09 as a tab stop
// (next multiple of 8) instead of a printable glyph.
module text_console
  import text_pkg::*;
#(
  parameter int WORD      = 32,
  parameter int BYTE_CNT  = 4,
  parameter int ADDRW     = 11,
  parameter int TRAM_HRES = TRAM_HRES_DEF,
  parameter int TRAM_VRES = TRAM_VRES_DEF
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_char,
  input  logic [WORD-9:0]     in_attr,
  output logic                busy,
  output logic [BYTE_CNT-1:0] tram_we,
  output logic [ADDRW-1:0]    tram_addr,
  output logic [WORD-1:0]     tram_din,
  output logic [ADDRW-1:0]    scroll_offs,
  output logic [6:0]          cur_col,
  output logic [4:0]          cur_row
);

  localparam int SIZE = TRAM_HRES * TRAM_VRES;

  localparam logic [6:0]       COL_LAST      = 7'(TRAM_HRES - 1);
  localparam logic [4:0]       ROW_LAST      = 5'(TRAM_VRES - 1);
  localparam logic [ADDRW-1:0] HRES_A        = ADDRW'(TRAM_HRES);
  localparam logic [ADDRW-1:0] HRES_LAST_A   = ADDRW'(TRAM_HRES - 1);
  localparam logic [ADDRW-1:0] SIZE_LAST_A   = ADDRW'(SIZE - 1);
  localparam logic [ADDRW-1:0] LAST_LINE_IDX = ADDRW'((TRAM_VRES - 1) * TRAM_HRES);

  state_t               state_q, state_d;
  logic [6:0]           col_q, col_d;
  logic [4:0]           row_q, row_d;
  logic [ADDRW-1:0]     offs_q, offs_d;
  logic [WORD-9:0]      attr_q, attr_d;
  logic                 adv_q, adv_d;      // line wrap pending after the write cycle
  logic [ADDRW-1:0]     cnt_q, cnt_d;      // clear progress, index of the word on the bus
  logic [BYTE_CNT-1:0]  we_q, we_d;
  logic [ADDRW-1:0]     addr_q, addr_d;
  logic [WORD-1:0]      din_q, din_d;

  logic [ADDRW-1:0]     row_idx;
  logic [ADDRW-1:0]     phys_offs;
  logic [ADDRW-1:0]     phys_idx;
  logic [ADDRW-1:0]     phys_addr;
  logic [ADDRW-1:0]     offs_adv;

`ifdef TEXT_CONSOLE_TAB_EN
  logic [7:0]           tab_col;
  assign tab_col = {({1'b0, col_q[6:3]} + 5'd1), 3'b000};
`endif

  assign row_idx = ADDRW'(row_q) * HRES_A + ADDRW'(col_q);

  // Write port outputs are registered, so each write is set up on the edge
  // that enters the cycle in which it must be visible.  The address adder is
  // therefore fed with the values that cycle will use: the new offset when
  // a scroll starts, the next column of the line being blanked otherwise.
  always_comb begin
    phys_offs = offs_q;
    phys_idx  = row_idx;
    case (state_q)
      ST_ADVANCE: begin
        phys_offs = offs_adv;
        phys_idx  = LAST_LINE_IDX;
      end
      ST_CLEAR_LINE: phys_idx = LAST_LINE_IDX + cnt_q + ADDRW'(1);
      default: ;
    endcase
  end

  tram_addr_wrap #(.ADDRW(ADDRW), .SIZE(SIZE)) u_phys (
    .offs (phys_offs),
    .idx  (phys_idx),
    .addr (phys_addr)
  );

  // One-line scroll step of the circular offset.
  tram_addr_wrap #(.ADDRW(ADDRW), .SIZE(SIZE)) u_scroll (
    .offs (offs_q),
    .idx  (HRES_A),
    .addr (offs_adv)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    offs_d  = offs_q;
    attr_d  = attr_q;
    adv_d   = adv_q;
    cnt_d   = cnt_q;
    we_d    = '0;
    addr_d  = addr_q;
    din_d   = din_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          attr_d = in_attr;
          adv_d  = 1'b0;
          // Cursor moves on acceptance; ST_WRITE is the single post-accept
          // cycle, carrying the tram write strobe when there is one.
          case (in_char)
            CH_LF: begin
              col_d   = '0;
              state_d = ST_ADVANCE;
            end
            CH_CR: begin
              col_d   = '0;
              state_d = ST_WRITE;
            end
            CH_BS: begin
              if (col_q != '0) col_d = col_q - 7'd1;
              state_d = ST_WRITE;
            end
            CH_FF: begin
              cnt_d   = '0;
              we_d    = '1;
              addr_d  = '0;
              din_d   = {in_attr, CH_SPACE};
              state_d = ST_CLEAR_ALL;
            end
`ifdef TEXT_CONSOLE_TAB_EN
            CH_TAB: begin
              if (tab_col >= 8'(TRAM_HRES)) begin
                col_d   = '0;
                state_d = ST_ADVANCE;
              end else begin
                col_d   = tab_col[6:0];
                state_d = ST_WRITE;
              end
            end
`endif
            default: begin
              we_d    = '1;
              addr_d  = phys_addr;
              din_d   = {in_attr, in_char};
              state_d = ST_WRITE;
              if (col_q < COL_LAST) begin
                col_d = col_q + 7'd1;
              end else begin
                col_d = '0;
                adv_d = 1'b1;
              end
            end
          endcase
        end
      end

      ST_WRITE: begin
        adv_d   = 1'b0;
        state_d = adv_q ? ST_ADVANCE : ST_IDLE;
      end

      ST_ADVANCE: begin
        if (row_q < ROW_LAST) begin
          row_d   = row_q + 5'd1;
          state_d = ST_IDLE;
        end else begin
          offs_d  = offs_adv;
          cnt_d   = '0;
          we_d    = '1;
          addr_d  = phys_addr;
          din_d   = {attr_q, CH_SPACE};
          state_d = ST_CLEAR_LINE;
        end
      end

      ST_CLEAR_LINE: begin
        if (cnt_q < HRES_LAST_A) begin
          cnt_d  = cnt_q + ADDRW'(1);
          we_d   = '1;
          addr_d = phys_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR_ALL: begin
        if (cnt_q < SIZE_LAST_A) begin
          cnt_d  = cnt_q + ADDRW'(1);
          we_d   = '1;
          addr_d = cnt_q + ADDRW'(1);
        end else begin
          offs_d  = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      offs_q  <= '0;
      attr_q  <= '0;
      adv_q   <= 1'b0;
      cnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      offs_q  <= offs_d;
      attr_q  <= attr_d;
      adv_q   <= adv_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign tram_we     = we_q;
  assign tram_addr   = addr_q;
  assign tram_din    = din_q;
  assign scroll_offs = offs_q;
  assign cur_col     = col_q;
  assign cur_row     = row_q;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: directed characters, write scoreboard, cursor/offset checks.
// Latency: n/a.
// Backpressure: stimulus waits on in_ready with a cycle bound.
module tb_text_console;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic [23:0] in_attr;
  logic        busy;
  logic [3:0]  tram_we;
  logic [10:0] tram_addr;
  logic [31:0] tram_din;
  logic [10:0] scroll_offs;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] din;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  int m_col = 0;
  int m_row = 0;
  int m_offs = 0;

  always #5 clk_sys = ~clk_sys;

  text_console dut (
    .clk_sys     (clk_sys),
    .rst_sys     (rst_sys),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .in_attr     (in_attr),
    .busy        (busy),
    .tram_we     (tram_we),
    .tram_addr   (tram_addr),
    .tram_din    (tram_din),
    .scroll_offs (scroll_offs),
    .cur_col     (cur_col),
    .cur_row     (cur_row)
  );

  // Monitor: every write strobe pops one expected write.
  always @(negedge clk_sys) begin
    if (mon_en && tram_we !== 4'h0) begin
      n_cmp = n_cmp + 1;
      if (sb_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_write: got we=%h addr=%0d din=%h, expected no write", tram_we, tram_addr, tram_din);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (tram_we !== 4'hF || tram_addr !== e.addr || tram_din !== e.din) begin
          n_err = n_err + 1;
          $display("FAIL tram_write: got we=%h addr=%0d din=%h, expected we=f addr=%0d din=%h",
                   tram_we, tram_addr, tram_din, e.addr, e.din);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int phys(input int r, input int c);
    int p;
    p = m_offs + r * 84 + c;
    if (p >= 2016) p = p - 2016;
    return p;
  endfunction

  task automatic push(input int a, input logic [31:0] d);
    exp_t e;
    e.addr = 11'(a);
    e.din  = d;
    sb_q.push_back(e);
  endtask

  task automatic model_adv(input logic [23:0] a);
    if (m_row < 23) begin
      m_row = m_row + 1;
    end else begin
      m_offs = m_offs + 84;
      if (m_offs >= 2016) m_offs = m_offs - 2016;
      for (int k = 0; k < 84; k++) push(phys(23, k), {a, 8'h20});
    end
  endtask

  task automatic model_char(input logic [7:0] c, input logic [23:0] a);
    case (c)
      8'h0A: begin m_col = 0; model_adv(a); end
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) m_col = m_col - 1;
      8'h0C: begin
        for (int k = 0; k < 2016; k++) push(k, {a, 8'h20});
        m_offs = 0; m_row = 0; m_col = 0;
      end
`ifdef TEXT_CONSOLE_TAB_EN
      8'h09: begin
        m_col = (m_col / 8 + 1) * 8;
        if (m_col >= 84) begin m_col = 0; model_adv(a); end
      end
`endif
      default: begin
        push(phys(m_row, m_col), {a, c});
        if (m_col < 83) m_col = m_col + 1;
        else begin m_col = 0; model_adv(a); end
      end
    endcase
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk_sys);
    while (in_ready !== 1'b1 && t < 5000) begin
      @(negedge clk_sys);
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, t);
    end
  endtask

  // Issue one character; returns just after the accepting edge.
  task automatic send(input logic [7:0] c, input logic [23:0] a);
    wait_ready();
    model_char(c, a);
    in_valid = 1'b1;
    in_char  = c;
    in_attr  = a;
    @(posedge clk_sys);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk_sys);
    while (in_ready !== 1'b1 && n < 5000) begin
      n++;
      @(negedge clk_sys);
    end
  endtask

  initial begin
    int nb;
    rst_sys  = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    in_attr  = 24'h0;
    repeat (3) @(posedge clk_sys);
    #1;
    rst_sys = 1'b0;
    @(negedge clk_sys);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tram_we", 32'(tram_we), 32'd0);
    chk("rst_tram_addr", 32'(tram_addr), 32'd0);
    chk("rst_tram_din", tram_din, 32'd0);
    chk("rst_scroll_offs", 32'(scroll_offs), 32'd0);
    chk("rst_cur_col", 32'(cur_col), 32'd0);
    chk("rst_cur_row", 32'(cur_row), 32'd0);
    mon_en = 1'b1;

    // First character: write visible one cycle after accept
    send(8'h41, 24'h00000F);
    @(negedge clk_sys);
    chk("A_we", 32'(tram_we), 32'hF);
    chk("A_addr", 32'(tram_addr), 32'd0);
    chk("A_din", tram_din, 32'h00000F41);
    chk("A_ready_n1", 32'(in_ready), 32'd0);
    @(negedge clk_sys);
    chk("A_ready_n2", 32'(in_ready), 32'd1);
    chk("A_col", 32'(cur_col), 32'd1);

    // CR then a full line of printables from (0,0)
    send(8'h0D, 24'h0);
    wait_ready();
    chk("cr_col", 32'(cur_col), 32'd0);
    for (int i = 0; i < 84; i++) send(8'h30 + 8'(i % 40), 24'h000007);
    wait_ready();
    chk("line_last_addr", 32'(tram_addr), 32'd83);
    chk("line_col", 32'(cur_col), 32'd0);
    chk("line_row", 32'(cur_row), 32'd1);
    chk("line_offs", 32'(scroll_offs), 32'd0);

    // Backspace at column 0 stays put
    send(8'h08, 24'h0);
    wait_ready();
    chk("bs_col0", 32'(cur_col), 32'd0);

    // Tab from column 5
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 24'h000002);
    send(8'h09, 24'h000003);
    wait_ready();
`ifdef TEXT_CONSOLE_TAB_EN
    chk("tab_col", 32'(cur_col), 32'd8);
`else
    chk("tab_col", 32'(cur_col), 32'd6);
    chk("tab_addr", 32'(tram_addr), 32'd89);
    chk("tab_din", tram_din, 32'h00000309);
`endif
    send(8'h08, 24'h0);
    wait_ready();
`ifdef TEXT_CONSOLE_TAB_EN
    chk("bs_col", 32'(cur_col), 32'd7);
`else
    chk("bs_col", 32'(cur_col), 32'd5);
`endif

    // Walk down to the last row
    for (int i = 0; i < 22; i++) send(8'h0A, 24'h0);
    wait_ready();
    chk("bottom_row", 32'(cur_row), 32'd23);
    chk("bottom_offs", 32'(scroll_offs), 32'd0);

    // First scroll: offset 0 -> 84, blanks at 0..83
    send(8'h0A, 24'h000011);
    count_busy(nb);
    chk("scroll1_busy_cycles", 32'(nb), 32'd85);
    chk("scroll1_offs", 32'(scroll_offs), 32'd84);
    chk("scroll1_row", 32'(cur_row), 32'd23);
    chk("scroll1_last_addr", 32'(tram_addr), 32'd83);
    chk("scroll1_din", tram_din, 32'h00001120);

    // Scroll until the offset sits on the last line
    for (int i = 0; i < 22; i++) send(8'h0A, 24'h0);
    wait_ready();
    chk("offs_1932", 32'(scroll_offs), 32'd1932);

    // Write at (23,0) with offset 1932 folds to 1848
    send(8'h5A, 24'h000123);
    wait_ready();
    chk("wrap_write_addr", 32'(tram_addr), 32'd1848);
    chk("wrap_write_din", tram_din, 32'h0001235A);

    // Offset wraps to 0, blanks at 1932..2015
    send(8'h0A, 24'h000044);
    wait_ready();
    chk("scroll_wrap_offs", 32'(scroll_offs), 32'd0);
    chk("scroll_wrap_last", 32'(tram_addr), 32'd2015);

    // Full clear from a nonzero offset and cursor
    send(8'h0A, 24'h0);
    send(8'h41, 24'h0);
    wait_ready();
    chk("pre_ff_offs", 32'(scroll_offs), 32'd84);
    send(8'h0C, 24'h000055);
    count_busy(nb);
    chk("ff_busy_cycles", 32'(nb), 32'd2016);
    chk("ff_offs", 32'(scroll_offs), 32'd0);
    chk("ff_col", 32'(cur_col), 32'd0);
    chk("ff_row", 32'(cur_row), 32'd0);
    chk("ff_last_addr", 32'(tram_addr), 32'd2015);

    // Reset in the middle of a clear
    send(8'h42, 24'h0);
    send(8'h0C, 24'h000066);
    repeat (50) @(posedge clk_sys);
    #1;
    chk("midclr_busy", 32'(busy), 32'd1);
    rst_sys = 1'b1;
    @(posedge clk_sys);
    #1;
    sb_q.delete();
    m_offs = 0; m_row = 0; m_col = 0;
    @(negedge clk_sys);
    chk("midclr_rst_we", 32'(tram_we), 32'd0);
    chk("midclr_rst_ready", 32'(in_ready), 32'd1);
    chk("midclr_rst_col", 32'(cur_col), 32'd0);
    @(posedge clk_sys);
    #1;
    rst_sys = 1'b0;

    // Operation resumes from the origin
    send(8'h43, 24'h000077);
    wait_ready();
    chk("post_rst_addr", 32'(tram_addr), 32'd0);
    chk("post_rst_din", tram_din, 32'h00007743);

    repeat (5) @(negedge clk_sys);
    chk("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
